// File: rtl/ram_dp_be.sv
// Dual-port byte-enable block RAM, one clock, optional collision flag (macro RAM_DP_BE_COLLISION_CHECK_EN).
// Latency: read data 1 cycle after access (OREG=0) or 2 cycles (OREG=1); rvalid tracks oe with the same delay.
// Backpressure: none; each port accepts one access per cycle, unconditionally.
module ram_dp_be #(
    parameter  int SCALE    = 10,
    parameter  int WIDTH    = 32,
    parameter  int OREG     = 0,
    parameter  int RDW_MODE = 0,
    localparam int NB       = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             oe0,
    input  logic [SCALE-1:0] addr0,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [NB-1:0]    we0,
    output logic [WIDTH-1:0] rdata0,
    output logic             rvalid0,
    input  logic             oe1,
    input  logic [SCALE-1:0] addr1,
    input  logic [WIDTH-1:0] wdata1,
    input  logic [NB-1:0]    we1,
    output logic [WIDTH-1:0] rdata1,
    output logic             rvalid1,
    output logic             collision
);

    localparam int DEPTH = 1 << SCALE;

    // Parameter sanity: an address width of zero or a non-byte-multiple word makes no sense.
    generate
        if (SCALE < 1 || (WIDTH % 8) != 0) begin : g_bad_params
`ifndef SYNTHESIS
            // Abort elaboration of an unusable configuration.
            initial begin
                $display("ram_dp_be: illegal parameters SCALE=%0d WIDTH=%0d", SCALE, WIDTH);
                $finish;
            end
`endif
        end
    endgenerate

    // Array starts at zero so never-written words read back as 0, not X.
    logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

    // Replace the byte lanes selected by en with the matching lanes of data.
    function automatic logic [WIDTH-1:0] merge_lanes(
        input logic [WIDTH-1:0] base,
        input logic [WIDTH-1:0] data,
        input logic [NB-1:0]    en
    );
        logic [WIDTH-1:0] res;
        res = base;
        for (int b = 0; b < NB; b++) begin
            if (en[b]) begin
                res[8*b +: 8] = data[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Words currently stored at each port's address (pre-write view of this cycle).
    logic [WIDTH-1:0] old0;
    logic [WIDTH-1:0] old1;
    assign old0 = mem[addr0];
    assign old1 = mem[addr1];

    // Each port's own view of the word after its own lane writes.
    logic [WIDTH-1:0] own0;
    logic [WIDTH-1:0] own1;
    assign own0 = merge_lanes(old0, wdata0, we0);
    assign own1 = merge_lanes(old1, wdata1, we1);

    // Both ports active on one word: lanes merge, and port 0 is applied last so it wins shared lanes.
    logic             same_addr;
    logic [WIDTH-1:0] both_word;
    assign same_addr = oe0 & oe1 & (addr0 == addr1);
    assign both_word = merge_lanes(own1, wdata0, we0);

    // Write enables are gated by reset so a write presented during reset is dropped.
    logic             wr0;
    logic             wr1;
    logic [WIDTH-1:0] wword0;
    logic [WIDTH-1:0] wword1;
    assign wr0    = rst & oe0 & (|we0);
    assign wr1    = rst & oe1 & (|we1);
    assign wword0 = same_addr ? both_word : own0;
    assign wword1 = same_addr ? both_word : own1;

    // Array update; on a shared address both ports store the identical merged word.
    always_ff @(posedge clk) begin
        if (wr1) begin
            mem[addr1] <= wword1;
        end
        if (wr0) begin
            mem[addr0] <= wword0;
        end
    end

    // Same-port read-during-write selection; the other port's write is never visible (read-first across ports).
    logic [WIDTH-1:0] rdw0;
    logic [WIDTH-1:0] rdw1;
    assign rdw0 = (RDW_MODE == 1) ? old0 : own0;
    assign rdw1 = (RDW_MODE == 1) ? old1 : own1;

    // First read stage: capture data on an access, hold otherwise; valid is the registered enable.
    logic [WIDTH-1:0] rd0_q;
    logic [WIDTH-1:0] rd1_q;
    logic             vld0_q;
    logic             vld1_q;

    // Port 0 read register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd0_q  <= '0;
            vld0_q <= 1'b0;
        end else begin
            vld0_q <= oe0;
            if (oe0) begin
                rd0_q <= rdw0;
            end
        end
    end

    // Port 1 read register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd1_q  <= '0;
            vld1_q <= 1'b0;
        end else begin
            vld1_q <= oe1;
            if (oe1) begin
                rd1_q <= rdw1;
            end
        end
    end

    generate
        if (OREG == 1) begin : g_oreg
            logic [WIDTH-1:0] rd0_o;
            logic [WIDTH-1:0] rd1_o;
            logic             vld0_o;
            logic             vld1_o;

            // Extra output stage; it copies stage one every cycle, so held data stays held.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    rd0_o  <= '0;
                    rd1_o  <= '0;
                    vld0_o <= 1'b0;
                    vld1_o <= 1'b0;
                end else begin
                    rd0_o  <= rd0_q;
                    rd1_o  <= rd1_q;
                    vld0_o <= vld0_q;
                    vld1_o <= vld1_q;
                end
            end

            assign rdata0  = rd0_o;
            assign rdata1  = rd1_o;
            assign rvalid0 = vld0_o;
            assign rvalid1 = vld1_o;
        end else begin : g_noreg
            assign rdata0  = rd0_q;
            assign rdata1  = rd1_q;
            assign rvalid0 = vld0_q;
            assign rvalid1 = vld1_q;
        end
    endgenerate

`ifdef RAM_DP_BE_COLLISION_CHECK_EN
    // A collision is a lane written by both ports at the same address in one cycle.
    logic coll_hit;
    logic coll_q;
    assign coll_hit = same_addr & (|(we0 & we1));

    // Sticky flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            coll_q <= 1'b0;
        end else if (coll_hit) begin
            coll_q <= 1'b1;
        end
    end

    assign collision = coll_q;

`ifndef SYNTHESIS
    int unsigned cyc;

    // Cycle count since reset, used only for the collision report.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc <= 0;
        end else begin
            cyc <= cyc + 1;
        end
    end

    // Report each collision event with its address and cycle.
    always_ff @(posedge clk) begin
        if (rst && coll_hit) begin
            $display("ram_dp_be: write collision at address %0h, cycle %0d", addr0, cyc);
        end
    end
`endif
`else
    assign collision = 1'b0;
`endif

endmodule
